// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the multi-cycle multiply/divide sequencer and its parent
// execute stage. The parent uses alu_ctrl_e when muxing the shared add/sub
// ALU between its own operands and those driven by muldiv_sequencer.
//
// Contents:
//   alu_ctrl_e     : ALU mode, same encoding as the ALU (ADD=0, SUB=1)
//   muldiv_op_e    : request opcode (MUL=0, DIV=1)
//   muldiv_state_e : sequencer FSM states
// -----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1
   } alu_ctrl_e;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

endpackage : muldiv_pkg

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Unsigned multi-cycle multiply / divide controller. All arithmetic goes
// through the parent's shared 32-bit add/sub ALU, one ALU operation per
// cycle: shift-add multiplication and restoring division, DATA_WIDTH
// iterations each. The parent hands the ALU to this block while busy_o is high.
//
// Build option:
//   MULDIV_DIV_EN defined   : full restoring divider.
//   MULDIV_DIV_EN undefined : divider not built; a DIV request goes straight
//                             to DONE with resp_lo_o = all-ones and
//                             resp_hi_o = dividend, busy_o never asserted.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake
//   req_op_i             0 = MUL, 1 = DIV
//   req_a_i, req_b_i     MUL: multiplicand, multiplier; DIV: dividend, divisor
//   resp_valid_i/ready_i response handshake
//   resp_lo_o, resp_hi_o MUL: product low/high; DIV: quotient/remainder
//   busy_o               ALU owned by this block
//   alu_op_a_o/b_o       ALU operands
//   alu_ctrl_o           ALU mode
//   alu_result_i         ALU output, combinational from alu_op_*
// -----------------------------------------------------------------------------
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_op_i,
   input  logic [DATA_WIDTH-1:0] req_a_i,
   input  logic [DATA_WIDTH-1:0] req_b_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_lo_o,
   output logic [DATA_WIDTH-1:0] resp_hi_o,
   output logic                  busy_o,
   output logic [DATA_WIDTH-1:0] alu_op_a_o,
   output logic [DATA_WIDTH-1:0] alu_op_b_o,
   output logic [CTRL_WIDTH-1:0] alu_ctrl_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_MUL  = ST_MUL;
`ifdef MULDIV_DIV_EN
   localparam logic [1:0] S_DIV  = ST_DIV;
`endif
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic                  mul_carry;

`ifdef MULDIV_DIV_EN
   logic                  op_q, op_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quot_q, quot_d;
   logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
   logic [DATA_WIDTH-1:0] div_rsh;
   logic                  div_top;
   logic                  div_ge;
`endif

   // Carry out of hi + mcand is recovered from the sum wrapping below hi,
   // since the ALU does not export its carry.
   assign mul_carry = (alu_result_i < hi_q);

`ifdef MULDIV_DIV_EN
   // Partial remainder shifted left by one with the next dividend bit;
   // div_top is the bit shifted out, making the trial compare 33 bits wide.
   assign div_rsh = {rem_q[DATA_WIDTH-2:0], quot_q[DATA_WIDTH-1]};
   assign div_top = rem_q[DATA_WIDTH-1];
   assign div_ge  = ({div_top, div_rsh} >= {1'b0, dvsr_q});
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      mcand_d    = mcand_q;
`ifdef MULDIV_DIV_EN
      op_d       = op_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      dvsr_d     = dvsr_q;
`endif
      alu_op_a_o = '0;
      alu_op_b_o = '0;
      alu_ctrl_o = CTRL_WIDTH'(ALU_ADD);

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               cnt_d = '0;
               if (req_op_i == OP_DIV) begin
`ifdef MULDIV_DIV_EN
                  op_d    = 1'b1;
                  rem_d   = '0;
                  quot_d  = req_a_i;
                  dvsr_d  = req_b_i;
                  state_d = S_DIV;
`else
                  // Divider absent: report the divide-by-zero shaped result.
                  lo_d    = '1;
                  hi_d    = req_a_i;
                  state_d = S_DONE;
`endif
               end else begin
`ifdef MULDIV_DIV_EN
                  op_d    = 1'b0;
`endif
                  hi_d    = '0;
                  lo_d    = req_b_i;
                  mcand_d = req_a_i;
                  state_d = S_MUL;
               end
            end
         end

         S_MUL: begin
            alu_op_a_o = hi_q;
            alu_op_b_o = mcand_q;
            alu_ctrl_o = CTRL_WIDTH'(ALU_ADD);
            // {hi,lo} shifts right one bit; multiplier bits leave through lo[0]
            // while product bits enter lo from the top.
            if (lo_q[0]) begin
               hi_d = {mul_carry, alu_result_i[DATA_WIDTH-1:1]};
               lo_d = {alu_result_i[0], lo_q[DATA_WIDTH-1:1]};
            end else begin
               hi_d = {1'b0, hi_q[DATA_WIDTH-1:1]};
               lo_d = {hi_q[0], lo_q[DATA_WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end

`ifdef MULDIV_DIV_EN
         S_DIV: begin
            alu_op_a_o = div_rsh;
            alu_op_b_o = dvsr_q;
            alu_ctrl_o = CTRL_WIDTH'(ALU_SUB);
            // When div_top is set the true difference still fits in
            // DATA_WIDTH bits, so the wrapped ALU result is exact.
            if (div_ge) begin
               rem_d  = alu_result_i;
               quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
               rem_d  = div_rsh;
               quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end
`endif

         S_DONE: begin
            if (resp_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
`ifdef MULDIV_DIV_EN
         op_q    <= 1'b0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
`ifdef MULDIV_DIV_EN
         op_q    <= op_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
`endif
      end
   end

   // Handshake and ownership flags come from the state register only.
   assign req_ready_o  = (state_q == S_IDLE);
   assign resp_valid_o = (state_q == S_DONE);

`ifdef MULDIV_DIV_EN
   assign busy_o    = (state_q == S_MUL) || (state_q == S_DIV);
   assign resp_lo_o = op_q ? quot_q : lo_q;
   assign resp_hi_o = op_q ? rem_q  : hi_q;
`else
   assign busy_o    = (state_q == S_MUL);
   assign resp_lo_o = lo_q;
   assign resp_hi_o = hi_q;
`endif

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Scoreboard bench for muldiv_sequencer. The bench plays the parent: it owns
// the add/sub ALU and closes the alu_op_* -> alu_result loop. Expected results
// are queued when a request is issued and compared on the response handshake.
// DIV expectations follow MULDIV_DIV_EN.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_op;
   logic [W-1:0]  req_a, req_b;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_lo, resp_hi;
   logic          busy;
   logic [W-1:0]  alu_op_a, alu_op_b;
   logic [2:0]    alu_ctrl;
   logic [W-1:0]  alu_result;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   // Parent's shared ALU.
   assign alu_result = (alu_ctrl == 3'd1) ? (alu_op_a - alu_op_b) : (alu_op_a + alu_op_b);

   muldiv_sequencer #(.DATA_WIDTH(W), .CTRL_WIDTH(3)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_op_i     (req_op),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_lo_o    (resp_lo),
      .resp_hi_o    (resp_hi),
      .busy_o       (busy),
      .alu_op_a_o   (alu_op_a),
      .alu_op_b_o   (alu_op_b),
      .alu_ctrl_o   (alu_ctrl),
      .alu_result_i (alu_result)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge while the DUT is idle; returns at the negedge of the
   // idle cycle following the response handshake.
   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input int exp_busy, input logic [2:0] exp_ctrl,
                         input int hold);
      exp_t         e;
      int           lat, nbusy, badctrl;
      logic [W-1:0] lo0, hi0;
      check_val("req_ready_idle", req_ready, 1);
      check_val("alu_op_a_idle", alu_op_a, 0);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      lat     = 1;
      nbusy   = 0;
      badctrl = 0;
      while (!resp_valid && lat < 200) begin
         if (busy) begin
            nbusy++;
            if (alu_ctrl !== exp_ctrl) badctrl++;
         end
         @(negedge clk);
         lat++;
      end
      check_val("resp_latency", 64'(lat), 64'(exp_lat));
      if (!resp_valid) return;
      check_val("busy_cycles", 64'(nbusy), 64'(exp_busy));
      check_val("alu_ctrl_busy", 64'(badctrl), 0);
      check_val("busy_in_done", busy, 0);
      check_val("req_ready_done", req_ready, 0);
      lo0 = resp_lo;
      hi0 = resp_hi;
      if (hold > 0) begin
         req_valid = 1'b1;
         req_op    = ~op;
         req_a     = 32'h0000_dead;
         req_b     = 32'h0000_beef;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_resp_valid", resp_valid, 1);
            check_val("hold_req_ready", req_ready, 0);
            check_val("hold_result", {resp_lo, resp_hi}, {lo0, hi0});
         end
      end
      resp_ready = 1'b1;
      if (sb_q.size() == 0) begin
         check_val("sb_nonempty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check_val("resp_lo", resp_lo, e.lo);
         check_val("resp_hi", resp_hi, e.hi);
      end
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check_val("post_hs_resp_valid", resp_valid, 0);
      check_val("post_hs_req_ready", req_ready, 1);
   endtask

   task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [63:0] p;
      p = {32'h0, a} * {32'h0, b};
      sb_q.push_back('{lo: p[31:0], hi: p[63:32]});
      run_op(1'b0, a, b, W + 1, W, 3'd0, hold);
   endtask

   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_DIV_EN
      if (b == 0) sb_q.push_back('{lo: 32'hFFFF_FFFF, hi: a});
      else        sb_q.push_back('{lo: a / b, hi: a % b});
      run_op(1'b1, a, b, W + 1, W, 3'd1, 0);
`else
      sb_q.push_back('{lo: 32'hFFFF_FFFF, hi: a});
      run_op(1'b1, a, b, 1, 0, 3'd1, 0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 1'b0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", req_ready, 1);
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_alu_a", alu_op_a, 0);
      check_val("rst_alu_b", alu_op_b, 0);
      check_val("rst_alu_ctrl", alu_ctrl, 0);
      check_val("rst_resp_lo", resp_lo, 0);
      check_val("rst_resp_hi", resp_hi, 0);
      rst_n = 1'b1;

      do_mul(32'd7, 32'd6, 0);
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_div(32'd100, 32'd7);
      do_div(32'h1234, 32'd0);
      do_div(32'd9, 32'd3);
      do_div(32'hFFFF_FFFF, 32'h1000_0001);
      do_mul(32'd0, 32'd12345, 0);
      do_mul(32'h8000_0000, 32'd2, 0);
      for (int i = 0; i < 4; i++) begin
         do_mul($urandom, $urandom, 0);
         do_div($urandom, $urandom_range(1, 1000));
      end
      // Backpressure with a pending request, then an immediate follow-on.
      do_mul(32'h0000_ABCD, 32'h0000_1234, 5);
      do_mul(32'h1357_9BDF, 32'h2468_ACE0, 0);

      // Abort a MUL partway through with reset.
      req_valid = 1'b1;
      req_op    = 1'b0;
      req_a     = 32'h1234_5678;
      req_b     = 32'h9ABC_DEF1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      check_val("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("abort_req_ready", req_ready, 1);
      check_val("abort_resp_valid", resp_valid, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_alu_a", alu_op_a, 0);
      check_val("abort_alu_b", alu_op_b, 0);
      check_val("abort_alu_ctrl", alu_ctrl, 0);
      check_val("abort_resp_lo", resp_lo, 0);
      check_val("abort_resp_hi", resp_hi, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_mul(32'd3, 32'd5, 0);

      check_val("sb_drained", 64'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_muldiv_sequencer

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle unsigned multiply/divide controller that performs its arithmetic through the shared 32-bit add/sub ALU. It iterates shift-add multiplication and restoring division, one ALU operation per cycle. It sits beside the ALU in the execute stage. The parent muxes the ALU operands and control to this block while `busy` is high.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `CTRL_WIDTH`, 3, ALU control width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_op`  in  1  0 = MUL, 1 = DIV
- `req_a`, `req_b`  in  DATA_WIDTH  operands:
  - MUL: multiplicand and multiplier
  - DIV: dividend and divisor
- `resp_valid`  out  1  result present
- `resp_ready`  in  1  consumer accepts result
- `resp_lo`  out  DATA_WIDTH  MUL: product[31:0]; DIV: quotient
- `resp_hi`  out  DATA_WIDTH  MUL: product[63:32]; DIV: remainder
- `busy`  out  1  ALU owned by this block (state MUL or DIV)
- `alu_op_a`, `alu_op_b`  out  DATA_WIDTH  ALU operands
- `alu_ctrl`  out  CTRL_WIDTH  ALU mode (ADD=0, SUB=1)
- `alu_result`  in  DATA_WIDTH  ALU output, combinational from `alu_op_*`

## Operation
- **States:** IDLE, MUL, DIV, DONE. Reset enters IDLE.
- **Reset values:** all data registers 0; `req_ready`=1; `resp_valid`=0; `busy`=0; `alu_*`=0.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, load registers, clear `cnt`, go to MUL or DIV per `req_op`.
  - ALU outputs driven 0.
- **MUL registers:** `hi`=0, `lo`=`req_b`, `mcand`=`req_a`.
- **MUL, each cycle:**
  - ALU drive: `alu_op_a`=`hi`, `alu_op_b`=`mcand`, ctrl ADD.
  - `carry` = (`alu_result` < `hi`), unsigned, computed internally.
  - If `lo[0]`: {`hi`,`lo`} ← {`carry`,`alu_result`,`lo`} >> 1.
  - Else: {`hi`,`lo`} ← {1'b0,`hi`,`lo`} >> 1.
- **DIV registers:** `rem`=0, `quot`=`req_a`, `dvsr`=`req_b`.
- **DIV, each cycle:**
  - Form `rsh` = {`rem`[W-2:0], `quot`[W-1]} and `top` = `rem`[W-1].
  - ALU drive: `alu_op_a`=`rsh`, `alu_op_b`=`dvsr`, ctrl SUB.
  - If {`top`,`rsh`} ≥ {0,`dvsr`} (33-bit internal compare): `rem` ← `alu_result`, `quot` ← {`quot`[W-2:0],1}.
  - Else: `rem` ← `rsh`, `quot` ← {`quot`[W-2:0],0}.
- **Iteration count:** `cnt` increments each iteration. At `cnt`==DATA_WIDTH−1 the final iteration commits and the state goes to DONE.
- **DONE:**
  - `resp_valid`=1; `resp_lo`/`resp_hi` = {`lo`,`hi`} for MUL or {`quot`,`rem`} for DIV, stable.
  - On `resp_ready`, go to IDLE.
- **Divide by zero:** falls out of the algorithm — quotient all-ones, remainder = dividend. No special case.
- **Arithmetic rules:** all arithmetic unsigned. ALU carry/borrow is never taken from the ALU.
- **Request acceptance:** requests are not accepted outside IDLE; `req_valid` is ignored there.
- **Reset mid-operation:** `rst_n` low in any state aborts immediately to reset values. No response is produced for the aborted request.

## Timing
- Acceptance edge = rising edge with `req_valid` & `req_ready`.
- `busy` high from the cycle after acceptance for exactly DATA_WIDTH cycles.
- `resp_valid` rises DATA_WIDTH+1 cycles after the acceptance edge (33 for W=32). It holds until the `resp_ready` edge.
- The earliest next acceptance is one cycle after the response handshake (IDLE cycle). Throughput is 1 op per DATA_WIDTH+2 cycles.
- `req_ready`, `resp_valid` and `busy` are decoded from the state register only; there is no combinational path from inputs.
- The `alu_op_*` → `alu_result` → register path is a single-cycle combinational loop through the external ALU.

## Configuration
- `MULDIV_DIV_EN` defined:
  - DIV path as above.
- `MULDIV_DIV_EN` undefined:
  - DIV state and divider registers are not compiled.
  - A DIV request goes IDLE → DONE directly, with `resp_lo`=all-ones and `resp_hi`=`req_a`.
  - `busy` stays 0 for that request.
  - MUL is unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - `alu_ctrl_e` (ALU_ADD=0, ALU_SUB=1; same encoding as the ALU)
  - `muldiv_op_e` (OP_MUL=0, OP_DIV=1)
  - `muldiv_state_e`
- The parent uses `alu_ctrl_e` for its ALU operand mux.
- No sub-module: the ALU is instanced by the parent, and this block is a single FSM with a datapath.

## Test plan
- MUL 7×6 → `resp_valid` at acceptance+33; `resp_lo`=42, `resp_hi`=0; `alu_ctrl`=0 while `busy`.
- MUL 0xFFFFFFFF×0xFFFFFFFF → `resp_hi`=0xFFFFFFFE, `resp_lo`=0x00000001 (carry path).
- DIV 100/7 → `resp_lo`=14, `resp_hi`=2; DIV 0x1234/0 → `resp_lo`=0xFFFFFFFF, `resp_hi`=0x1234.
- `resp_ready` held low 5 cycles after DONE, with `req_valid` asserted → outputs stable, `req_ready`=0; accept the next request one cycle after the handshake.
- `rst_n` pulsed low at iteration 10 of a MUL → outputs at reset values immediately; a fresh MUL 3×5 then returns 15.
- Build without `MULDIV_DIV_EN`: DIV 9/3 → `resp_valid` 1 cycle after acceptance, `resp_lo`=0xFFFFFFFF, `resp_hi`=9, `busy` never high.
